// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes rx, finds the start edge,
// samples each bit at its centre and strobes out the received word.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int IW   = $clog2(DATA_BITS);

   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [IW-1:0]        idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic [DATA_BITS-1:0] data_n;
   logic                 valid_n, ferr_n;
   logic                 sync1, rx_s, rx_q;
   logic                 fall;

   assign fall = !rx_s & rx_q;
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         // Line-idle level, so leaving reset never looks like a start edge
         sync1     <= 1'b1;
         rx_s      <= 1'b1;
         rx_q      <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync1     <= rx;
         rx_s      <= sync1;
         rx_q      <= rx_s;
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         sh        <= sh_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      sh_n    = sh;
      data_n  = data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (fall) state_n = START;
         end
         START: begin
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_n = '0;
               sh_n  = {rx_s, sh[DATA_BITS-1:1]};
               if (idx == LAST) state_n = STOP;
               else             idx_n   = idx + 1'b1;
            end
         end
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_n   = '0;
               state_n = IDLE;
               data_n  = sh;
               valid_n = rx_s;
               ferr_n  = !rx_s;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives serial frames at
// 16 clk/bit and compares strobes against a frame-level model.
module tb_uart_rx_ctrl;

   localparam int CPB  = 16;
   localparam int DB   = 8;
   localparam int HALF = CPB / 2;
   // rx -> fall takes two synchronizer cycles, then the frame latency
   localparam int LAT  = 2 + 1 + HALF + (DB + 1) * CPB;
   localparam int FBUSY = HALF + (DB + 1) * CPB;

   typedef struct {
      int         cyc;
      logic       v;
      logic       fe;
      logic [7:0] d;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx  = 1'b1;
   logic [DB-1:0] data;
   logic         valid;
   logic         frame_err;
   logic         busy;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;
   int   both_cnt = 0;
   int   bad_data = 0;
   logic rst_d = 1'b1;
   logic [DB-1:0] pdata;
   ev_t  evq[$];
   ev_t  exq[$];

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .data(data),
      .valid(valid),
      .frame_err(frame_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_d <= rst;
   end

   // Recorder: logs strobes and tallies invariant violations
   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
      if (valid === 1'b1 || frame_err === 1'b1)
         evq.push_back('{cyc, valid, frame_err, data});
      else if (!rst_d && data !== pdata)
         bad_data++;
      pdata = data;
   end

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop,
                             output int t0);
      t0 = cyc;
      hold(1'b0, CPB);
      for (int i = 0; i < DB; i++) hold(b[i], CPB);
      hold(stop, CPB);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", valid);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ferr: got %b expected 0", frame_err);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h expected 00", data);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_idle_high();
      int b0;
      evq.delete();
      b0 = busy_cnt;
      hold(1'b1, 200);
      checks++;
      if (evq.size() != 0) begin
         errors++;
         $display("FAIL idle_events: got %0d expected 0", evq.size());
      end
      checks++;
      if (busy_cnt != b0) begin
         errors++;
         $display("FAIL idle_busy: got %0d expected 0", busy_cnt - b0);
      end
      checks++;
      if (data !== 8'h00) begin
         errors++;
         $display("FAIL idle_data: got %h expected 00", data);
      end
   endtask

   task automatic test_single();
      int t0, b0;
      evq.delete();
      b0 = busy_cnt;
      send_frame(8'h55, 1'b1, t0);
      hold(1'b1, 20);
      checks++;
      if (evq.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d expected 1", evq.size());
      end else begin
         checks++;
         if (evq[0].cyc != t0 + LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d expected %0d",
                     evq[0].cyc - t0, LAT);
         end
         checks++;
         if (evq[0].v !== 1'b1 || evq[0].fe !== 1'b0 || evq[0].d !== 8'h55) begin
            errors++;
            $display("FAIL single_event: got v%b fe%b %h expected v1 fe0 55",
                     evq[0].v, evq[0].fe, evq[0].d);
         end
      end
      checks++;
      if (busy_cnt - b0 != FBUSY) begin
         errors++;
         $display("FAIL single_busy: got %0d expected %0d", busy_cnt - b0, FBUSY);
      end
      checks++;
      if (data !== 8'h55) begin
         errors++;
         $display("FAIL single_hold: got %h expected 55", data);
      end
   endtask

   task automatic test_back_to_back();
      int t0, t1, b0;
      evq.delete();
      b0 = busy_cnt;
      send_frame(8'hA3, 1'b1, t0);
      send_frame(8'h0F, 1'b1, t1);
      hold(1'b1, 20);
      checks++;
      if (evq.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 2", evq.size());
      end else begin
         checks++;
         if (evq[1].cyc - evq[0].cyc != (DB + 2) * CPB) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected %0d",
                     evq[1].cyc - evq[0].cyc, (DB + 2) * CPB);
         end
         checks++;
         if (evq[0].d !== 8'hA3 || evq[1].d !== 8'h0F ||
             evq[0].v !== 1'b1 || evq[1].v !== 1'b1) begin
            errors++;
            $display("FAIL b2b_data: got %h/%h v%b%b expected a3/0f v11",
                     evq[0].d, evq[1].d, evq[0].v, evq[1].v);
         end
         checks++;
         if (evq[1].cyc != t1 + LAT) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected %0d",
                     evq[1].cyc - t1, LAT);
         end
      end
      checks++;
      if (busy_cnt - b0 != 2 * FBUSY) begin
         errors++;
         $display("FAIL b2b_busy: got %0d expected %0d", busy_cnt - b0, 2 * FBUSY);
      end
   endtask

   task automatic test_glitch();
      int b0;
      evq.delete();
      b0 = busy_cnt;
      hold(1'b0, 3);
      hold(1'b1, 30);
      checks++;
      if (evq.size() != 0) begin
         errors++;
         $display("FAIL glitch_events: got %0d expected 0", evq.size());
      end
      checks++;
      if (busy_cnt - b0 != HALF) begin
         errors++;
         $display("FAIL glitch_busy: got %0d expected %0d", busy_cnt - b0, HALF);
      end
      checks++;
      if (data !== 8'h0F) begin
         errors++;
         $display("FAIL glitch_data: got %h expected 0f", data);
      end
   endtask

   task automatic test_frame_err();
      int t0, b0;
      evq.delete();
      b0 = busy_cnt;
      send_frame(8'h81, 1'b0, t0);
      hold(1'b0, 40);
      hold(1'b1, 30);
      checks++;
      if (evq.size() != 1) begin
         errors++;
         $display("FAIL ferr_count: got %0d expected 1", evq.size());
      end else begin
         checks++;
         if (evq[0].v !== 1'b0 || evq[0].fe !== 1'b1 || evq[0].d !== 8'h81) begin
            errors++;
            $display("FAIL ferr_event: got v%b fe%b %h expected v0 fe1 81",
                     evq[0].v, evq[0].fe, evq[0].d);
         end
         checks++;
         if (evq[0].cyc != t0 + LAT) begin
            errors++;
            $display("FAIL ferr_latency: got %0d expected %0d",
                     evq[0].cyc - t0, LAT);
         end
      end
      checks++;
      if (busy_cnt - b0 != FBUSY) begin
         errors++;
         $display("FAIL ferr_busy: got %0d expected %0d", busy_cnt - b0, FBUSY);
      end
   endtask

   task automatic test_reset_midframe();
      int t0;
      evq.delete();
      hold(1'b0, CPB);
      hold(1'b1, 4 * CPB + HALF);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got busy%b %h v%b fe%b expected busy0 00 v0 fe0",
                  busy, data, valid, frame_err);
      end
      hold(1'b1, HALF - 1 + 4 * CPB);
      checks++;
      if (evq.size() != 0) begin
         errors++;
         $display("FAIL rst_abort: got %0d events expected 0", evq.size());
      end
      send_frame(8'h3C, 1'b1, t0);
      hold(1'b1, 20);
      checks++;
      if (evq.size() != 1) begin
         errors++;
         $display("FAIL rst_next_count: got %0d expected 1", evq.size());
      end else begin
         checks++;
         if (evq[0].d !== 8'h3C || evq[0].v !== 1'b1 || evq[0].cyc != t0 + LAT) begin
            errors++;
            $display("FAIL rst_next: got %h v%b lat%0d expected 3c v1 lat%0d",
                     evq[0].d, evq[0].v, evq[0].cyc - t0, LAT);
         end
      end
   endtask

   task automatic test_random();
      int         t0, gap;
      logic [7:0] b;
      logic       stop;
      evq.delete();
      exq.delete();
      for (int k = 0; k < 10; k++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         gap  = stop ? $urandom_range(0, 12) : $urandom_range(1, 12);
         send_frame(b, stop, t0);
         exq.push_back('{t0 + LAT, stop, !stop, b});
         hold(1'b1, gap);
      end
      hold(1'b1, 30);
      checks++;
      if (evq.size() != exq.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d expected %0d", evq.size(), exq.size());
      end else begin
         for (int i = 0; i < exq.size(); i++) begin
            checks++;
            if (evq[i].cyc != exq[i].cyc || evq[i].v !== exq[i].v ||
                evq[i].fe !== exq[i].fe || evq[i].d !== exq[i].d) begin
               errors++;
               $display("FAIL rand_frame%0d: got c%0d v%b fe%b %h expected c%0d v%b fe%b %h",
                        i, evq[i].cyc, evq[i].v, evq[i].fe, evq[i].d,
                        exq[i].cyc, exq[i].v, exq[i].fe, exq[i].d);
            end
         end
      end
   endtask

   task automatic test_invariants();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL inv_both: got %0d expected 0", both_cnt);
      end
      checks++;
      if (bad_data != 0) begin
         errors++;
         $display("FAIL inv_data_hold: got %0d expected 0", bad_data);
      end
   endtask

   initial begin
      test_reset();
      test_idle_high();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_midframe();
      test_random();
      test_invariants();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
